// File: rtl/morse_pkg.sv
// Shared state encoding, Morse timing constants and LEN legality check
// for the Morse keyer controller.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [2:0] DOT_UNITS        = 3'd1;
    localparam logic [2:0] DASH_UNITS       = 3'd3;
    localparam logic [2:0] ELEM_GAP_UNITS   = 3'd1;
    localparam logic [2:0] LETTER_GAP_UNITS = 3'd3;
    localparam logic [2:0] WORD_GAP_UNITS   = 3'd7;
    localparam logic [2:0] MAX_LEN          = 3'd5;

    function automatic logic len_legal(input logic [2:0] len);
        return (len != 3'd0) && (len <= MAX_LEN);
    endfunction

endpackage

// File: rtl/morse_keyer_ctrl_if.sv
// Character request / key-line bundle between a character source and the keyer.
interface morse_keyer_ctrl_if;

    logic       START;
    logic [4:0] PATTERN;
    logic [2:0] LEN;
    logic       WORD_END;
    logic       KEY;
    logic       BUSY;
    logic       DONE;
    logic       ERR;

    modport master (
        output START, PATTERN, LEN, WORD_END,
        input  KEY, BUSY, DONE, ERR
    );

    modport slave (
        input  START, PATTERN, LEN, WORD_END,
        output KEY, BUSY, DONE, ERR
    );

endinterface

// File: rtl/morse_unit_timer.sv
// Divides the clock into Morse time units: one-cycle tick every UNIT_CYCLES
// cycles, restarted by a synchronous clear on every state entry.
module morse_unit_timer #(
    parameter int unsigned UNIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned TW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(UNIT_CYCLES - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + TW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/morse_keyer_ctrl.sv
// Morse keyer controller: keys one character (up to 5 dots/dashes) followed
// by a letter or word gap, timed in units of UNIT_CYCLES clocks.
module morse_keyer_ctrl #(
    parameter int unsigned UNIT_CYCLES = 4
) (
    input  logic                CLK,
    input  logic                RST,
    morse_keyer_ctrl_if.slave   bus
);

    import morse_pkg::*;

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [4:0] pattern_q, pattern_d;
    logic [2:0] len_q, len_d;
    logic       word_end_q, word_end_d;
    logic       key_q, key_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [2:0] unit_q, unit_d;

    logic       tick;
    logic       clr;
    logic       expire;
    logic       accept;
    logic       idle_like;
    logic [2:0] dur;

    morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
        .clk  (CLK),
        .rst  (RST),
        .clr  (clr),
        .tick (tick)
    );

    assign clr = accept | expire;

    always_comb begin
        unit_d = unit_q;
        if (clr || (state_q == ST_IDLE)) begin
            unit_d = '0;
        end else if (tick) begin
            unit_d = unit_q + 3'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pattern_d  = pattern_q;
        len_d      = len_q;
        word_end_d = word_end_q;
        key_d      = key_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        accept     = 1'b0;

        case (state_q)
            ST_MARK:  dur = pattern_q[idx_q] ? DASH_UNITS : DOT_UNITS;
            ST_SPACE: dur = ELEM_GAP_UNITS;
            ST_GAP:   dur = word_end_q ? WORD_GAP_UNITS : LETTER_GAP_UNITS;
            default:  dur = DOT_UNITS;
        endcase

        expire = (state_q != ST_IDLE) && tick && (unit_q == dur - 3'd1);

        case (state_q)
            ST_MARK: begin
                if (expire) begin
                    key_d   = 1'b0;
                    state_d = ((idx_q + 3'd1) < len_q) ? ST_SPACE : ST_GAP;
                end
            end
            ST_SPACE: begin
                if (expire) begin
                    idx_d   = idx_q + 3'd1;
                    key_d   = 1'b1;
                    state_d = ST_MARK;
                end
            end
            ST_GAP: begin
                if (expire) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: ;
        endcase

        // The DONE cycle doubles as an IDLE sampling point so held START chains characters.
        idle_like = (state_q == ST_IDLE) || ((state_q == ST_GAP) && expire);
        if (idle_like && bus.START) begin
            if (len_legal(bus.LEN)) begin
                accept     = 1'b1;
                pattern_d  = bus.PATTERN;
                len_d      = bus.LEN;
                word_end_d = bus.WORD_END;
                idx_d      = '0;
                state_d    = ST_MARK;
                key_d      = 1'b1;
                busy_d     = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            pattern_q  <= '0;
            len_q      <= '0;
            word_end_q <= 1'b0;
            key_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            unit_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pattern_q  <= pattern_d;
            len_q      <= len_d;
            word_end_q <= word_end_d;
            key_q      <= key_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            unit_q     <= unit_d;
        end
    end

    assign bus.KEY  = key_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.ERR  = err_q;

endmodule

// File: doc/morse_keyer_ctrl.md
MORSE_KEYER_CTRL -- requirements
Module: morse_keyer_ctrl

Interface
REQ-001 Parameter UNIT_CYCLES, default 4, SHALL set the number of CLK cycles per Morse time unit (U); legal range 1..255.
REQ-002 CLK  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 RST  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 START  input  1  SHALL request transmission of one character; sampled only in IDLE.
REQ-005 PATTERN  input  5  SHALL hold the element code, LSB first; 0=dot, 1=dash; bits at index >= LEN are ignored.
REQ-006 LEN  input  3  SHALL hold the number of elements; legal 1..5.
REQ-007 WORD_END  input  1  SHALL select the trailing gap: 1=word gap, 0=letter gap.
REQ-008 KEY  output  1  SHALL be the registered Morse key line driving the transmitter datapath (1=tone on).
REQ-009 BUSY  output  1  SHALL be high while a character is in progress.
REQ-010 DONE  output  1  SHALL pulse high for one cycle when a character and its trailing gap complete.
REQ-011 ERR  output  1  SHALL pulse high for one cycle when START is sampled with LEN=0 or LEN>5.

Function
REQ-012 FSM states SHALL be IDLE, MARK, SPACE and GAP.
REQ-013 Durations SHALL be: dot 1 U, dash 3 U, inter-element space 1 U, letter gap 3 U, word gap 7 U.
REQ-014 In IDLE with START=1 and legal LEN, the FSM SHALL latch PATTERN, LEN and WORD_END, enter MARK, and set KEY=1 and BUSY=1 on that same edge.
REQ-015 In IDLE with START=1 and illegal LEN, the FSM SHALL remain in IDLE, pulse ERR and leave KEY and BUSY at 0.
REQ-016 When MARK expires, the FSM SHALL go to SPACE (KEY=0) if elements remain, otherwise to GAP (KEY=0).
REQ-017 When SPACE expires, the FSM SHALL advance the element index and re-enter MARK with KEY=1.
REQ-018 When GAP expires, the FSM SHALL enter IDLE, drive BUSY=0 and pulse DONE=1 in that cycle.
REQ-019 A START held high in the DONE cycle SHALL be accepted there, so back-to-back characters are gapless beyond the specified gap.
REQ-020 START, PATTERN, LEN and WORD_END changes while BUSY=1 SHALL be ignored; there is no queuing.
REQ-021 The unit counter SHALL be 3 bits (max 7); the tick counter SHALL be ceil(log2(UNIT_CYCLES)) bits (minimum 1) and SHALL wrap to 0 on each unit tick.
REQ-022 Total cycles from acceptance to DONE SHALL be U*(sum of marks + (LEN-1) + gap) + 1.

Reset
REQ-023 With RST=1 at a rising edge, the FSM SHALL enter IDLE and drive KEY=0, BUSY=0, DONE=0 and ERR=0, and SHALL clear all counters and latched inputs.
REQ-024 RST SHALL take priority over START and over any in-progress character; an aborted character SHALL NOT produce DONE.

Structure
REQ-025 Shared package morse_pkg SHALL hold the state encoding and the constants DOT_UNITS=1, DASH_UNITS=3, ELEM_GAP_UNITS=1, LETTER_GAP_UNITS=3, WORD_GAP_UNITS=7 and MAX_LEN=5.
REQ-026 Sub-module morse_unit_timer SHALL generate a one-cycle unit tick every UNIT_CYCLES cycles, with a synchronous clear asserted on every state entry.

Verification (UNIT_CYCLES=2; cycle 1 = first cycle after the accepting edge)
REQ-027 Reset: RST=1 for 2 cycles mid-run -> KEY=0, BUSY=0, DONE=0, ERR=0.
REQ-028 "E": PATTERN=00000, LEN=1, WORD_END=0, START for 1 cycle -> KEY=1 in cycles 1-2, KEY=0 in cycles 3-8, DONE=1 and BUSY=0 in cycle 9.
REQ-029 "A": PATTERN=00010, LEN=2 -> KEY high 1-2, low 3-4, high 5-10, low 11-16, DONE in cycle 17.
REQ-030 Word gap: "E" with WORD_END=1 -> KEY low in cycles 3-16, DONE in cycle 17; START held through DONE -> next character's KEY rises in cycle 17.
REQ-031 Errors and ignored requests: LEN=0 -> ERR pulse for 1 cycle, BUSY stays 0; START with LEN=6 while BUSY=1 -> no ERR and no effect.
REQ-032 Abort: RST=1 during cycle 4 of a dash -> KEY=0 and BUSY=0 on the next edge, and no DONE follows.
